// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter in front of a shared
// WIDTH-bit holding register. At most one requester is accepted per cycle.
// The winner's word is stored, its index is recorded in owner, and it gets
// a one-cycle registered grant.
//
// Handshake (req/gnt): requester i raises req[i] and holds its data slice
// stable until it sees gnt[i] high. gnt[i] is high for exactly the cycle
// after the write. In that cycle requester i is masked out of arbitration,
// so it may drop req[i] or present its next word. A new word becomes
// eligible from the following cycle.
module reg_write_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      data_out,
  output logic [IDX_W-1:0]      owner,
  output logic                  valid
);

  logic [NREQ-1:0]  gnt_q,   gnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [IDX_W-1:0] win;

  // A requester holding its grant this cycle cannot win again.
  assign elig = req & ~gnt_q;

  // Rotating search starting at ptr. Indices wrap modulo NREQ, so the
  // winner is never an index of NREQ or higher.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = int'(ptr_q) + k;
      if (i >= NREQ) i = i - NREQ;
      if (!found && elig[i]) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
  end

  // Next-state: write the winner's word, or go idle and only clear the grant.
  always_comb begin
    gnt_d   = '0;
    data_d  = data_q;
    owner_d = owner_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      data_d     = data_in[int'(win)*WIDTH +: WIDTH];
      owner_d    = win;
      valid_d    = 1'b1;
      ptr_d      = (win == IDX_W'(NREQ-1)) ? '0 : win + 1'b1;
    end
  end

  // State registers. Reset discards any write that would land on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign data_out = data_q;
  assign owner    = owner_q;
  assign valid    = valid_q;

endmodule
